snoop_coherence_ctrl: RTL and testbench
=======================================

# snoop_coherence_ctrl

Parametrised MSI snooping-coherence subsystem for NUM_PROC private write-back caches sharing one bus and one main memory. It replaces the free-running step counter with a transaction FSM and a valid/ready instruction handshake. It generalises processor count, tag/data width and cache depth, and adds Modified-state ownership, victim write-back, invalidation on write hit and error reporting. It sits at the top of the coherence design, driven by the instruction stimulus source.

## Interface
Parameters:
- NUM_PROC, 4, number of processor caches (≥2); PROC_W = max(1, $clog2(NUM_PROC))
- TAG_W, 3, address width; memory holds 2^TAG_W words
- DATA_W, 4, data word width
- LINES, 2, direct-mapped lines per cache (power of two); IDX_W = $clog2(LINES), index = tag[IDX_W-1:0]

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- instr_valid  in  1  instruction present
- instr_ready  out  1  controller idle, accepts instruction
- instr  in  1+PROC_W+TAG_W+DATA_W  {op, proc, tag, value}, MSB first; op 0 = read, 1 = write
- resp_valid  out  1  one-cycle completion pulse
- resp_data  out  DATA_W  read result, or written value for writes
- resp_hit  out  1  request hit in requester cache
- resp_err  out  1  proc ≥ NUM_PROC
- bus_msg  out  2  bus message this cycle: 0 none, 1 ReadMiss, 2 WriteMiss/RdX, 3 Invalidate
- bus_wb  out  1  memory write-back this cycle

## Operation
- Line state is one of I, S, M, plus stored tag and data.
- A line matches when its state is not I and its stored tag equals the request tag.
- FSM states: IDLE, LOOKUP, WB, BUS, DONE.
- IDLE: instr_ready=1. On instr_valid, latch instr and go to LOOKUP.
- LOOKUP, proc invalid: go to DONE with resp_err=1; no state change.
- LOOKUP, read hit: go to DONE.
- LOOKUP, write hit in M: update data, go to DONE.
- LOOKUP, write hit in S: go to BUS as Invalidate.
- LOOKUP, miss: go to WB if the victim line is M, otherwise go to BUS.
- WB: write victim data to mem[victim tag], bus_wb=1, then go to BUS.
- BUS ReadMiss:
  - If another cache matches in M, it writes back to memory (bus_wb=1), supplies data and downgrades to S.
  - Otherwise data comes from memory.
  - Requester line becomes S.
- BUS WriteMiss: any M owner writes back (bus_wb=1); all other matching lines go to I; requester becomes M with value.
- BUS Invalidate: other matching lines go to I; requester goes S→M with value.
- DONE: resp_valid=1, then return to IDLE.
- Invariant: at most one M copy per tag; M excludes any S copies.

## Timing
- Reset values:
  - all lines I, tag 0, data 0; all mem words 0; FSM in IDLE
  - instr_ready=1, resp_valid=0, resp_data=0, resp_hit=0, resp_err=0, bus_msg=0, bus_wb=0
- Latency, counted as cycles after the acceptance edge until resp_valid:
  - hit or error: 2
  - miss or Invalidate: 3
  - miss with victim write-back: 4
- instr_ready is 0 from LOOKUP through DONE; instr_valid is ignored then. Only one transaction is in flight.
- Response outputs hold their values until the next DONE.
- bus_msg and bus_wb are nonzero only in BUS/WB cycles.
- Reset asserted mid-transaction aborts it: no resp_valid, all arrays are cleared, next cycle is IDLE.
- Reset and instr_valid in the same cycle: reset wins, instruction dropped.

## Structure
- Package snoop_pkg holds:
  - msi_t {I, S, M}
  - bus_msg_t
  - fsm_t
  - instruction field-slicing constants
- Sub-module snoop_cache is instantiated NUM_PROC times. It owns the line arrays and provides:
  - combinational lookup and snoop-match outputs
  - registered update on commands from the FSM
- Memory array and FSM live in the top module.

## Test plan
- Reset; P0 read tag 5 → 3 cycles, resp_data=0, resp_hit=0, bus_msg=1, P0 line1 S.
- P1 write tag 5 value 9 → WriteMiss; P0 line1 I, P1 M=9. Then P0 read tag 5 → bus_wb=1, mem[5]=9, resp_data=9, P0 and P1 both S.
- P1 (M tag 5 = 9) reads tag 7, same index → WB then BUS, 4 cycles; mem[5]=9, P1 S tag 7.
- P0 and P2 in S on tag 2; P0 writes 4 → Invalidate, 3 cycles; P2 I, P0 M=4. Repeat the write → hit, 2 cycles, no bus_msg.
- With NUM_PROC=3, proc=3 → resp_err=1 in 2 cycles, no array change.
- Reset asserted during BUS → no resp_valid, instr_ready=1 next cycle, subsequent read of tag 5 returns 0.

Source files
------------

// File: rtl/snoop_pkg.sv
// ---------------------------------------------------------------------------
// snoop_pkg
// Shared types and helpers for the MSI snooping coherence controller.
//   msi_t      : per-line coherence state (Invalid, Shared, Modified)
//   bus_msg_t  : message driven on the shared snoop bus for one cycle
//   fsm_t      : transaction FSM encoding, plus the state constants
//   helpers    : instruction field positions; the instruction word is
//                {op, proc, tag, value}, MSB first
// ---------------------------------------------------------------------------
package snoop_pkg;

  typedef enum logic [1:0] {
    MSI_I = 2'd0,
    MSI_S = 2'd1,
    MSI_M = 2'd2
  } msi_t;

  typedef enum logic [1:0] {
    BUS_NONE   = 2'd0,
    BUS_RDMISS = 2'd1,
    BUS_WRMISS = 2'd2,
    BUS_INV    = 2'd3
  } bus_msg_t;

  // Plain vector encoding keeps the state register readable by older tools.
  typedef logic [2:0] fsm_t;
  localparam fsm_t ST_IDLE   = 3'd0;
  localparam fsm_t ST_LOOKUP = 3'd1;
  localparam fsm_t ST_WB     = 3'd2;
  localparam fsm_t ST_BUS    = 3'd3;
  localparam fsm_t ST_DONE   = 3'd4;

  localparam logic OP_WRITE = 1'b1;

  // A processor id field is never narrower than one bit, even for tiny systems.
  function automatic int procWidth(input int numProc);
    int w;
    w = $clog2(numProc);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int tagLsb(input int dataW);
    return dataW;
  endfunction

  function automatic int procLsb(input int tagW, input int dataW);
    return tagW + dataW;
  endfunction

  function automatic int opBit(input int numProc, input int tagW, input int dataW);
    return procWidth(numProc) + tagW + dataW;
  endfunction

  function automatic int instrWidth(input int numProc, input int tagW, input int dataW);
    return opBit(numProc, tagW, dataW) + 1;
  endfunction

endpackage

// File: rtl/snoop_cache.sv
// ---------------------------------------------------------------------------
// snoop_cache
// One private direct-mapped cache: line state, tag and data arrays.
// The line is selected by the low tag bits of the request currently held by
// the controller; the same line serves as requester line, snoop target and
// eviction victim, so one index and one write port are enough.
// Ports:
//   clock, reset    rising-edge clock, synchronous active-high clear
//   lookup_tag_i    tag of the transaction in flight
//   match_o         selected line is valid and holds lookup_tag_i
//   state_o/tag_o/data_o  contents of the selected line
//   wr_en_i         overwrite the selected line with wr_state/tag/data_i
// ---------------------------------------------------------------------------
module snoop_cache
  import snoop_pkg::*;
#(
  parameter int TAG_W  = 3,
  parameter int DATA_W = 4,
  parameter int LINES  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [TAG_W-1:0]  lookup_tag_i,
  output logic              match_o,
  output msi_t              state_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              wr_en_i,
  input  msi_t              wr_state_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  localparam int IDX_W = (LINES > 1) ? $clog2(LINES) : 1;

  msi_t              state_q [LINES];
  logic [TAG_W-1:0]  tag_q   [LINES];
  logic [DATA_W-1:0] data_q  [LINES];

  logic [IDX_W-1:0]  idx;

  assign idx     = lookup_tag_i[IDX_W-1:0];
  assign state_o = state_q[idx];
  assign tag_o   = tag_q[idx];
  assign data_o  = data_q[idx];
  assign match_o = (state_q[idx] != MSI_I) && (tag_q[idx] == lookup_tag_i);

  // The controller decides every line change; this block just commits it.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LINES; i++) begin
        state_q[i] <= MSI_I;
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
      end
    end else if (wr_en_i) begin
      state_q[idx] <= wr_state_i;
      tag_q[idx]   <= wr_tag_i;
      data_q[idx]  <= wr_data_i;
    end
  end

endmodule

// File: rtl/snoop_coherence_ctrl.sv
// ---------------------------------------------------------------------------
// snoop_coherence_ctrl
// MSI snooping coherence for NUM_PROC write-back caches on one bus with one
// main memory. One instruction at a time is taken through
// IDLE -> LOOKUP -> [WB] -> [BUS] -> DONE.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   instr_valid/ready     instruction handshake, ready only in IDLE
//   instr                 {op, proc, tag, value}; op 1 = write
//   resp_valid            one-cycle completion pulse (DONE)
//   resp_data/hit/err     response, held until the next completion
//   bus_msg               0 none, 1 ReadMiss, 2 WriteMiss, 3 Invalidate
//   bus_wb                memory write-back happening this cycle
// ---------------------------------------------------------------------------
module snoop_coherence_ctrl
  import snoop_pkg::*;
#(
  parameter int NUM_PROC = 4,
  parameter int TAG_W    = 3,
  parameter int DATA_W   = 4,
  parameter int LINES    = 2
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          instr_valid,
  output logic                                          instr_ready,
  input  logic [instrWidth(NUM_PROC, TAG_W, DATA_W)-1:0] instr,
  output logic                                          resp_valid,
  output logic [DATA_W-1:0]                             resp_data,
  output logic                                          resp_hit,
  output logic                                          resp_err,
  output logic [1:0]                                    bus_msg,
  output logic                                          bus_wb
);

  localparam int PROC_W    = procWidth(NUM_PROC);
  localparam int INSTR_W   = instrWidth(NUM_PROC, TAG_W, DATA_W);
  localparam int OP_BIT    = opBit(NUM_PROC, TAG_W, DATA_W);
  localparam int PROC_LSB  = procLsb(TAG_W, DATA_W);
  localparam int TAG_LSB   = tagLsb(DATA_W);
  localparam int MEM_WORDS = 1 << TAG_W;
  localparam logic [PROC_W:0] NUM_PROC_V = NUM_PROC[PROC_W:0];

  fsm_t               state_q, state_d;
  logic [INSTR_W-1:0] req_q, req_d;
  bus_msg_t           busMsg_q, busMsg_d;
  logic               pendHit_q, pendHit_d;
  logic [DATA_W-1:0]  respData_q, respData_d;
  logic               respHit_q, respHit_d;
  logic               respErr_q, respErr_d;
  logic [DATA_W-1:0]  mem_q [MEM_WORDS];

  logic               reqOp;
  logic [PROC_W-1:0]  reqProc;
  logic [TAG_W-1:0]   reqTag;
  logic [DATA_W-1:0]  reqValue;
  logic               procValid;

  logic               cMatch [NUM_PROC];
  msi_t               cState [NUM_PROC];
  logic [TAG_W-1:0]   cTag   [NUM_PROC];
  logic [DATA_W-1:0]  cData  [NUM_PROC];
  logic               wrEn    [NUM_PROC];
  msi_t               wrState [NUM_PROC];
  logic [TAG_W-1:0]   wrTag   [NUM_PROC];
  logic [DATA_W-1:0]  wrData  [NUM_PROC];

  logic               reqMatch;
  msi_t               reqState;
  logic [TAG_W-1:0]   reqLineTag;
  logic [DATA_W-1:0]  reqLineData;
  logic               ownerFound;
  logic [DATA_W-1:0]  ownerData;

  logic               memWe;
  logic [TAG_W-1:0]   memAddr;
  logic [DATA_W-1:0]  memWdata;
  logic [DATA_W-1:0]  fill;
  bus_msg_t           busMsgOut;
  logic               busWbOut;

  assign reqOp     = req_q[OP_BIT];
  assign reqProc   = req_q[PROC_LSB +: PROC_W];
  assign reqTag    = req_q[TAG_LSB +: TAG_W];
  assign reqValue  = req_q[DATA_W-1:0];
  assign procValid = ({1'b0, reqProc} < NUM_PROC_V);

  for (genvar g = 0; g < NUM_PROC; g++) begin : gCache
    snoop_cache #(
      .TAG_W  (TAG_W),
      .DATA_W (DATA_W),
      .LINES  (LINES)
    ) uCache (
      .clock        (clock),
      .reset        (reset),
      .lookup_tag_i (reqTag),
      .match_o      (cMatch[g]),
      .state_o      (cState[g]),
      .tag_o        (cTag[g]),
      .data_o       (cData[g]),
      .wr_en_i      (wrEn[g]),
      .wr_state_i   (wrState[g]),
      .wr_tag_i     (wrTag[g]),
      .wr_data_i    (wrData[g])
    );
  end

  // Separate the requester's own line from what the other caches snoop.
  // Only another cache can be the M owner that must supply data.
  always_comb begin
    reqMatch    = 1'b0;
    reqState    = MSI_I;
    reqLineTag  = '0;
    reqLineData = '0;
    ownerFound  = 1'b0;
    ownerData   = '0;
    for (int p = 0; p < NUM_PROC; p++) begin
      if (PROC_W'(p) == reqProc) begin
        reqMatch    = cMatch[p];
        reqState    = cState[p];
        reqLineTag  = cTag[p];
        reqLineData = cData[p];
      end else if (cMatch[p] && (cState[p] == MSI_M)) begin
        ownerFound = 1'b1;
        ownerData  = cData[p];
      end
    end
  end

  // Transaction FSM. Response registers change only on the step into DONE,
  // so the previous response stays visible while a new one is in flight.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    busMsg_d   = busMsg_q;
    pendHit_d  = pendHit_q;
    respData_d = respData_q;
    respHit_d  = respHit_q;
    respErr_d  = respErr_q;
    memWe      = 1'b0;
    memAddr    = reqTag;
    memWdata   = reqValue;
    fill       = mem_q[reqTag];
    busMsgOut  = BUS_NONE;
    busWbOut   = 1'b0;
    for (int p = 0; p < NUM_PROC; p++) begin
      wrEn[p]    = 1'b0;
      wrState[p] = cState[p];
      wrTag[p]   = cTag[p];
      wrData[p]  = cData[p];
    end

    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          req_d   = instr;
          state_d = ST_LOOKUP;
        end
      end

      ST_LOOKUP: begin
        if (!procValid) begin
          respData_d = '0;
          respHit_d  = 1'b0;
          respErr_d  = 1'b1;
          state_d    = ST_DONE;
        end else if (reqMatch && (reqOp != OP_WRITE)) begin
          respData_d = reqLineData;
          respHit_d  = 1'b1;
          respErr_d  = 1'b0;
          state_d    = ST_DONE;
        end else if (reqMatch && (reqState == MSI_M)) begin
          // Sole owner: the write stays local, no bus traffic.
          for (int p = 0; p < NUM_PROC; p++) begin
            if (PROC_W'(p) == reqProc) begin
              wrEn[p]   = 1'b1;
              wrData[p] = reqValue;
            end
          end
          respData_d = reqValue;
          respHit_d  = 1'b1;
          respErr_d  = 1'b0;
          state_d    = ST_DONE;
        end else if (reqMatch) begin
          busMsg_d  = BUS_INV;
          pendHit_d = 1'b1;
          state_d   = ST_BUS;
        end else begin
          busMsg_d  = (reqOp == OP_WRITE) ? BUS_WRMISS : BUS_RDMISS;
          pendHit_d = 1'b0;
          state_d   = (reqState == MSI_M) ? ST_WB : ST_BUS;
        end
      end

      ST_WB: begin
        // The dirty victim shares the index but holds a different tag.
        memWe    = 1'b1;
        memAddr  = reqLineTag;
        memWdata = reqLineData;
        busWbOut = 1'b1;
        state_d  = ST_BUS;
      end

      ST_BUS: begin
        busMsgOut = busMsg_q;
        if ((busMsg_q != BUS_INV) && ownerFound) begin
          memWe    = 1'b1;
          memAddr  = reqTag;
          memWdata = ownerData;
          busWbOut = 1'b1;
        end
        if (busMsg_q == BUS_RDMISS) begin
          fill = ownerFound ? ownerData : mem_q[reqTag];
        end else begin
          fill = reqValue;
        end
        for (int p = 0; p < NUM_PROC; p++) begin
          if (PROC_W'(p) == reqProc) begin
            wrEn[p]    = 1'b1;
            wrState[p] = (busMsg_q == BUS_RDMISS) ? MSI_S : MSI_M;
            wrTag[p]   = reqTag;
            wrData[p]  = fill;
          end else if (cMatch[p]) begin
            // A read leaves sharers alone and demotes the owner; a write
            // or upgrade removes every other copy.
            wrEn[p] = 1'b1;
            if (busMsg_q == BUS_RDMISS) begin
              wrState[p] = (cState[p] == MSI_M) ? MSI_S : cState[p];
            end else begin
              wrState[p] = MSI_I;
            end
          end
        end
        respData_d = fill;
        respHit_d  = pendHit_q;
        respErr_d  = 1'b0;
        state_d    = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset wins over everything, including an instruction offered that cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      busMsg_q   <= BUS_NONE;
      pendHit_q  <= 1'b0;
      respData_q <= '0;
      respHit_q  <= 1'b0;
      respErr_q  <= 1'b0;
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      busMsg_q   <= busMsg_d;
      pendHit_q  <= pendHit_d;
      respData_q <= respData_d;
      respHit_q  <= respHit_d;
      respErr_q  <= respErr_d;
      if (memWe) begin
        mem_q[memAddr] <= memWdata;
      end
    end
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign resp_valid  = (state_q == ST_DONE);
  assign resp_data   = respData_q;
  assign resp_hit    = respHit_q;
  assign resp_err    = respErr_q;
  assign bus_msg     = busMsgOut;
  assign bus_wb      = busWbOut;

endmodule

// File: tb/tb_snoop_coherence_ctrl.sv
// ---------------------------------------------------------------------------
// tb_snoop_coherence_ctrl
// Directed scoreboard bench for snoop_coherence_ctrl with three processors.
// The driver pushes the hand-computed response of each instruction when it
// offers it; an independent monitor pops an entry on every resp_valid and
// compares data, hit, error, latency and the bus activity seen meanwhile.
// ---------------------------------------------------------------------------
module tb_snoop_coherence_ctrl;

  localparam int NUM_PROC = 3;
  localparam int TAG_W    = 3;
  localparam int DATA_W   = 4;
  localparam int LINES    = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic       instr_ready;
  logic [9:0] instr;
  logic       resp_valid;
  logic [3:0] resp_data;
  logic       resp_hit;
  logic       resp_err;
  logic [1:0] bus_msg;
  logic       bus_wb;

  snoop_coherence_ctrl #(
    .NUM_PROC (NUM_PROC),
    .TAG_W    (TAG_W),
    .DATA_W   (DATA_W),
    .LINES    (LINES)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .resp_hit    (resp_hit),
    .resp_err    (resp_err),
    .bus_msg     (bus_msg),
    .bus_wb      (bus_wb)
  );

  always #5 clock = ~clock;

  int cycleCnt = 0;
  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  typedef struct {
    string      name;
    logic [3:0] data;
    bit         chkData;
    logic       hit;
    logic       err;
    int         lat;
    logic [1:0] msg;
    logic       wb;
    int         acceptCycle;
  } exp_t;

  exp_t scoreQ[$];
  exp_t monE;
  int total = 0;
  int bad   = 0;
  logic [1:0] msgSeen;
  logic       wbSeen;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Latency counts the cycle after the acceptance edge as cycle 1, so the
  // negedge before acceptance is recorded as the reference point.
  task automatic applyStimulus(input string name, input logic op, input logic [1:0] proc,
                               input logic [2:0] tag, input logic [3:0] value,
                               input logic [3:0] eData, input bit chkData, input logic eHit,
                               input logic eErr, input int eLat, input logic [1:0] eMsg,
                               input logic eWb);
    exp_t e;
    int waitCnt;
    @(negedge clock);
    waitCnt = 0;
    while (!instr_ready && waitCnt < 50) begin
      @(negedge clock);
      waitCnt++;
    end
    if (!instr_ready) begin
      checkOutput({name, ".ready_wait"}, instr_ready, 1);
      return;
    end
    instr_valid = 1'b1;
    instr = {op, proc, tag, value};
    e.name = name; e.data = eData; e.chkData = chkData; e.hit = eHit; e.err = eErr;
    e.lat = eLat; e.msg = eMsg; e.wb = eWb; e.acceptCycle = cycleCnt;
    scoreQ.push_back(e);
    @(negedge clock);
    instr_valid = 1'b0;
    instr = '0;
    checkOutput({name, ".busy_ready"}, instr_ready, 0);
    waitCnt = 0;
    while (scoreQ.size() != 0 && waitCnt < 20) begin
      @(negedge clock);
      waitCnt++;
    end
    if (scoreQ.size() != 0) begin
      checkOutput({name, ".timeout"}, scoreQ.size(), 0);
      scoreQ.delete();
    end
  endtask

  // Monitor: accumulates bus activity per transaction and scores responses.
  initial begin
    msgSeen = '0;
    wbSeen  = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (reset) begin
        msgSeen = '0;
        wbSeen  = 1'b0;
      end else begin
        if (bus_msg != 2'd0) msgSeen = bus_msg;
        if (bus_wb) wbSeen = 1'b1;
        if (resp_valid) begin
          if (scoreQ.size() == 0) begin
            checkOutput("unexpected_resp", resp_valid, 0);
          end else begin
            monE = scoreQ.pop_front();
            if (monE.chkData) checkOutput({monE.name, ".data"}, resp_data, monE.data);
            checkOutput({monE.name, ".hit"}, resp_hit, monE.hit);
            checkOutput({monE.name, ".err"}, resp_err, monE.err);
            checkOutput({monE.name, ".latency"}, cycleCnt - monE.acceptCycle, monE.lat);
            checkOutput({monE.name, ".bus_msg"}, msgSeen, monE.msg);
            checkOutput({monE.name, ".bus_wb"}, wbSeen, monE.wb);
          end
          msgSeen = '0;
          wbSeen  = 1'b0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int waitCnt;
    reset = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    checkOutput("rst.ready",     instr_ready, 1);
    checkOutput("rst.resp_valid", resp_valid, 0);
    checkOutput("rst.resp_data",  resp_data, 0);
    checkOutput("rst.resp_hit",   resp_hit, 0);
    checkOutput("rst.resp_err",   resp_err, 0);
    checkOutput("rst.bus_msg",    bus_msg, 0);
    checkOutput("rst.bus_wb",     bus_wb, 0);

    //            name          op  proc tag   value  data  chk hit err lat msg wb
    applyStimulus("p0_rd5",     0, 2'd0, 3'd5, 4'd0,  4'd0,  1, 0, 0, 3, 2'd1, 0);
    applyStimulus("p0_rd5_hit", 0, 2'd0, 3'd5, 4'd0,  4'd0,  1, 1, 0, 2, 2'd0, 0);
    applyStimulus("p1_wr5",     1, 2'd1, 3'd5, 4'd9,  4'd9,  1, 0, 0, 3, 2'd2, 0);
    applyStimulus("p0_rd5_own", 0, 2'd0, 3'd5, 4'd0,  4'd9,  1, 0, 0, 3, 2'd1, 1);
    applyStimulus("p1_rd5_hit", 0, 2'd1, 3'd5, 4'd0,  4'd9,  1, 1, 0, 2, 2'd0, 0);
    applyStimulus("p1_wr5_inv", 1, 2'd1, 3'd5, 4'd11, 4'd11, 1, 1, 0, 3, 2'd3, 0);
    applyStimulus("p1_rd7_wb",  0, 2'd1, 3'd7, 4'd0,  4'd0,  1, 0, 0, 4, 2'd1, 1);
    applyStimulus("p2_rd5_mem", 0, 2'd2, 3'd5, 4'd0,  4'd11, 1, 0, 0, 3, 2'd1, 0);
    applyStimulus("p0_rd2",     0, 2'd0, 3'd2, 4'd0,  4'd0,  1, 0, 0, 3, 2'd1, 0);
    applyStimulus("p2_rd2",     0, 2'd2, 3'd2, 4'd0,  4'd0,  1, 0, 0, 3, 2'd1, 0);
    applyStimulus("p0_wr2_inv", 1, 2'd0, 3'd2, 4'd4,  4'd4,  1, 1, 0, 3, 2'd3, 0);
    applyStimulus("p0_wr2_hit", 1, 2'd0, 3'd2, 4'd4,  4'd4,  1, 1, 0, 2, 2'd0, 0);
    applyStimulus("p2_rd2_own", 0, 2'd2, 3'd2, 4'd0,  4'd4,  1, 0, 0, 3, 2'd1, 1);
    applyStimulus("p3_wr2_err", 1, 2'd3, 3'd2, 4'd15, 4'd0,  0, 0, 1, 2, 2'd0, 0);
    applyStimulus("p0_rd2_hit", 0, 2'd0, 3'd2, 4'd0,  4'd4,  1, 1, 0, 2, 2'd0, 0);

    // Abort a write miss while it is on the bus.
    @(negedge clock);
    instr_valid = 1'b1;
    instr = {1'b1, 2'd0, 3'd6, 4'd3};
    @(negedge clock);
    instr_valid = 1'b0;
    instr = '0;
    waitCnt = 0;
    while (bus_msg == 2'd0 && waitCnt < 10) begin
      @(negedge clock);
      waitCnt++;
    end
    checkOutput("abort.bus_msg", bus_msg, 2);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("abort.resp_valid", resp_valid, 0);
    checkOutput("abort.ready", instr_ready, 1);
    @(negedge clock);
    reset = 1'b0;
    checkOutput("abort.resp_data", resp_data, 0);
    repeat (4) @(negedge clock);
    applyStimulus("post_rd5",   0, 2'd0, 3'd5, 4'd0,  4'd0,  1, 0, 0, 3, 2'd1, 0);
    applyStimulus("post_rd2",   0, 2'd0, 3'd2, 4'd0,  4'd0,  1, 0, 0, 3, 2'd1, 0);

    // Instruction offered in the same cycle as reset must be dropped.
    @(negedge clock);
    reset = 1'b1;
    instr_valid = 1'b1;
    instr = {1'b1, 2'd1, 3'd3, 4'd7};
    @(negedge clock);
    reset = 1'b0;
    instr_valid = 1'b0;
    instr = '0;
    repeat (4) @(negedge clock);
    checkOutput("collide.ready", instr_ready, 1);
    applyStimulus("p1_rd3",     0, 2'd1, 3'd3, 4'd0,  4'd0,  1, 0, 0, 3, 2'd1, 0);

    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
